// File: rtl/proc_core_pkg.sv
// Shared opcode, FSM state and field-width definitions for the parametrised accumulator core.
// Pure declarations: no latency or flow control of its own.
package proc_core_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_LDR  = 4'h2,
    OP_STR  = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_AND  = 4'h6,
    OP_OR   = 4'h7,
    OP_XOR  = 4'h8,
    OP_SHL  = 4'h9,
    OP_SHR  = 4'hA,
    OP_JMP  = 4'hB,
    OP_JZ   = 4'hC,
    OP_JC   = 4'hD,
    OP_JR   = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/proc_core_regfile.sv
// NREG x DATA_W register file: one synchronous write port, one asynchronous read port.
// Write lands on the rising edge; read is combinational; no backpressure.
module proc_core_regfile
  import proc_core_pkg::*;
#(
  parameter int NREG   = 16,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = regs[raddr];

endmodule

// File: rtl/proc_core_param.sv
// Parametrised accumulator + register-file core; PROC_CORE_TRACE_EN adds RETIRE/RETIRE_PC trace ports.
// FETCH -> EXEC, two cycles minimum per instruction; FETCH holds PC and INST_REQ until INST_VALID.
module proc_core_param
  import proc_core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int NREG   = 16,
  parameter int INST_W = 8
) (
  input  logic              CLK,
  input  logic              CLB,
  output logic              INST_REQ,
  output logic [PC_W-1:0]   PC,
  input  logic              INST_VALID,
  input  logic [INST_W-1:0] INST,
  output logic [DATA_W-1:0] ACC,
  output logic              HALTED
`ifdef PROC_CORE_TRACE_EN
  ,
  output logic              RETIRE,
  output logic [PC_W-1:0]   RETIRE_PC
`endif
);

  localparam int OPND_W = INST_W - OPC_W;
  localparam int RA_W   = $clog2(NREG);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              z_q, z_d;
  logic              c_q, c_d;

  opcode_e           op;
  logic [OPND_W-1:0] opnd;
  logic [RA_W-1:0]   ra;
  logic [DATA_W-1:0] imm_d;
  logic [PC_W-1:0]   imm_pc;
  logic [DATA_W-1:0] rf_rdata;
  logic              rf_we;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;

  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_upd;

  assign op     = opcode_e'(ir_q[INST_W-1 -: OPC_W]);
  assign opnd   = ir_q[OPND_W-1:0];
  assign ra     = opnd[RA_W-1:0];
  assign imm_d  = DATA_W'(opnd);
  assign imm_pc = PC_W'(opnd);

  // Top bit of the widened result is the carry (ADD) or borrow (SUB) out of the MSB.
  assign sum  = {1'b0, acc_q} + {1'b0, rf_rdata};
  assign diff = {1'b0, acc_q} - {1'b0, rf_rdata};

  proc_core_regfile #(
    .NREG   (NREG),
    .DATA_W (DATA_W),
    .AW     (RA_W)
  ) u_rf (
    .clk   (CLK),
    .rst   (CLB),
    .we    (rf_we),
    .waddr (ra),
    .wdata (acc_q),
    .raddr (ra),
    .rdata (rf_rdata)
  );

  always_ff @(posedge CLK or posedge CLB) begin
    if (CLB) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    acc_d    = acc_q;
    z_d      = z_q;
    c_d      = c_q;
    rf_we    = 1'b0;
    INST_REQ = 1'b0;
    HALTED   = 1'b0;
    alu_res  = acc_q;
    alu_c    = c_q;
    alu_upd  = 1'b0;

    case (state_q)
      ST_FETCH: begin
        INST_REQ = 1'b1;
        if (INST_VALID) begin
          ir_d    = INST;
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_d = ST_FETCH;
        case (op)
          OP_NOP: ;
          OP_LDI: begin
            acc_d = imm_d;
            z_d   = (imm_d == '0);
          end
          OP_LDR: begin
            acc_d = rf_rdata;
            z_d   = (rf_rdata == '0);
          end
          OP_STR: rf_we = 1'b1;
          OP_ADD: begin
            {alu_c, alu_res} = sum;
            alu_upd          = 1'b1;
          end
          OP_SUB: begin
            {alu_c, alu_res} = diff;
            alu_upd          = 1'b1;
          end
          OP_AND: begin
            alu_res = acc_q & rf_rdata;
            alu_c   = 1'b0;
            alu_upd = 1'b1;
          end
          OP_OR: begin
            alu_res = acc_q | rf_rdata;
            alu_c   = 1'b0;
            alu_upd = 1'b1;
          end
          OP_XOR: begin
            alu_res = acc_q ^ rf_rdata;
            alu_c   = 1'b0;
            alu_upd = 1'b1;
          end
          OP_SHL: begin
            alu_res = {acc_q[DATA_W-2:0], 1'b0};
            alu_c   = acc_q[DATA_W-1];
            alu_upd = 1'b1;
          end
          OP_SHR: begin
            alu_res = {1'b0, acc_q[DATA_W-1:1]};
            alu_c   = acc_q[0];
            alu_upd = 1'b1;
          end
          // Jumps replace the PC+1 taken at fetch; flags tested are the pre-EXEC values.
          OP_JMP: pc_d = imm_pc;
          OP_JZ:  if (z_q) pc_d = imm_pc;
          OP_JC:  if (c_q) pc_d = imm_pc;
          OP_JR:  pc_d = PC_W'(rf_rdata);
          OP_HALT: state_d = ST_HALT;
          default: ;
        endcase
        if (alu_upd) begin
          acc_d = alu_res;
          c_d   = alu_c;
          z_d   = (alu_res == '0);
        end
      end

      ST_HALT: HALTED = 1'b1;

      default: state_d = ST_FETCH;
    endcase
  end

  assign PC  = pc_q;
  assign ACC = acc_q;

`ifdef PROC_CORE_TRACE_EN
  logic [PC_W-1:0] ret_pc_q;

  always_ff @(posedge CLK or posedge CLB) begin
    if (CLB) begin
      ret_pc_q <= '0;
    end else if (state_q == ST_FETCH && INST_VALID) begin
      ret_pc_q <= pc_q;
    end
  end

  assign RETIRE    = (state_q == ST_EXEC);
  assign RETIRE_PC = ret_pc_q;
`endif

endmodule
